// File: rtl/systolic_result_drain.sv
// systolic_result_drain: swaps a column's result bank, snapshots it and
// streams each element to result memory over a valid/ready write port.
module systolic_result_drain #(
  parameter int data_size        = 8,
  parameter int systolic_size    = 2,
  parameter int memory_data_size = 16,
  parameter int addr_width       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [addr_width-1:0]       base_addr,
  input  logic [data_size-1:0]        result_in [0:systolic_size-1],
  output logic                        mem_change,
  output logic                        mem_ele_cho,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [addr_width-1:0]       wr_addr,
  output logic [memory_data_size-1:0] wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = (systolic_size > 1) ? $clog2(systolic_size) : 1;
  localparam logic [IW-1:0] LAST = IW'(systolic_size - 1);

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t                state;
  logic [addr_width-1:0] addr_reg;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [data_size-1:0]  res_buf [0:systolic_size-1];

  assign idx_nxt = idx + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_reg    <= '0;
      idx         <= '0;
      res_buf     <= '{default: '0};
      mem_change  <= 1'b0;
      mem_ele_cho <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_change <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_reg   <= base_addr;
            idx        <= '0;
            mem_change <= 1'b1;
            busy       <= 1'b1;
            state      <= SWAP;
          end
        end
        SWAP: begin
          mem_ele_cho <= ~mem_ele_cho;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < systolic_size; i++)
            res_buf[i] <= result_in[i];
          // element 0 goes straight to the port; buffer fills this edge
          wr_valid <= 1'b1;
          wr_addr  <= addr_reg;
          wr_data  <= memory_data_size'(result_in[0]);
          state    <= SEND;
        end
        SEND: begin
          if (wr_ready) begin
            if (idx == LAST) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              idx     <= idx_nxt;
              wr_addr <= addr_reg + addr_width'(idx_nxt);
              wr_data <= memory_data_size'(res_buf[idx_nxt]);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
